// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, framing constants and baud divisor helper
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with registered full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_rd;
    logic             w_do_wr;
    logic [AW:0]      w_count_nxt;

    // A pop in the same cycle frees a slot, so a full FIFO can still take a write.
    assign w_do_rd = rd_en && !r_empty;
    assign w_do_wr = wr_en && (!r_full || w_do_rd);

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_wr && !w_do_rd) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_do_wr && w_do_rd) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered 8N1 UART transmitter with internal baud timing
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       tx
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int STOP_CLKS    = CLKS_PER_BIT * STOP_BITS;
    localparam int CW           = $clog2(STOP_CLKS + 1);
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t        r_state;
    logic [CW-1:0]    r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_sh;
    logic             r_tx;
    logic             r_busy;
    logic             r_overflow;

    logic [7:0]       w_dout;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .din   (din),
        .rd_en (w_pop),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Pop from idle, or on the last stop-bit cycle so the next start bit follows with no gap.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) ||
                    (r_state == ST_STOP && r_baud_cnt == STOP_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_sh       <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && (w_count == CNT_W'(FIFO_DEPTH)) && !w_pop;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_sh       <= w_dout;
                        r_baud_cnt <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_baud_cnt == BIT_LAST) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_sh[0];
                        r_state    <= ST_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_baud_cnt == BIT_LAST) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_sh      <= {1'b0, r_sh[7:1]};
                            r_tx      <= r_sh[1];
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_baud_cnt == STOP_LAST) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_sh    <= w_dout;
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign overflow = r_overflow;
    assign full     = w_full;
    assign empty    = w_empty;

endmodule
